// File: rtl/button_event_ctrl.sv
// Button gesture decoder: classifies a debounced level into short-click,
// long-press and double-click pulses, all registered on the state edge.
module button_event_ctrl #(
    parameter int unsigned CW     = 16,
    parameter int unsigned LONG_T = 100,
    parameter int unsigned GAP_T  = 50
) (
    input  logic clk,
    input  logic reset,
    input  logic db_level,
    output logic short_press,
    output logic long_press,
    output logic double_click,
    output logic busy
);

    typedef enum logic [2:0] {
        IDLE,
        DOWN1,
        HELD,
        UP1,
        DOWN2
    } state_e;

    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_T - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_T - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          prev_q;
    logic          short_q, short_d;
    logic          long_q, long_d;
    logic          dbl_q, dbl_d;
    logic          busy_q, busy_d;
    logic          rise, fall;

    assign rise = db_level & ~prev_q;
    assign fall = ~db_level & prev_q;

    // prev resets high so a button held through reset is not seen as a press
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prev_q  <= 1'b1;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            dbl_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prev_q  <= db_level;
            short_q <= short_d;
            long_q  <= long_d;
            dbl_q   <= dbl_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        short_d = 1'b0;
        long_d  = 1'b0;
        dbl_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = DOWN1;
                    cnt_d   = '0;
                end
            end
            DOWN1: begin
                if (fall) begin
                    state_d = UP1;
                    cnt_d   = '0;
                end else if (db_level) begin
                    if (cnt_q == LONG_LAST) begin
                        state_d = HELD;
                        long_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            HELD: begin
                if (fall) begin
                    state_d = IDLE;
                end
            end
            UP1: begin
                // a second press wins over the gap expiring on the same edge
                if (rise) begin
                    state_d = DOWN2;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                    short_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DOWN2: begin
                if (fall) begin
                    state_d = IDLE;
                    dbl_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    assign short_press  = short_q;
    assign long_press   = long_q;
    assign double_click = dbl_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Bench for button_event_ctrl: directed gestures plus random level runs,
// checked against a timestamp-based gesture model.
module tb_button_event_ctrl;

    localparam int LONG_T = 8;
    localparam int GAP_T  = 4;

    logic clk = 1'b0;
    logic reset;
    logic db_level;
    logic short_press, long_press, double_click, busy;

    int n_checks = 0;
    int n_errors = 0;

    // model: absolute edge index of press/release events, -1 when absent
    int k = 0;
    int tp1 = -1, tr1 = -1, tp2 = -1;
    bit lng = 0;
    bit mprev = 1;
    bit m_short = 0, m_long = 0, m_dbl = 0, m_busy = 0;

    int c_short, c_long, c_dbl;
    int k_short, k_long, k_dbl;

    button_event_ctrl #(
        .CW    (16),
        .LONG_T(LONG_T),
        .GAP_T (GAP_T)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .db_level    (db_level),
        .short_press (short_press),
        .long_press  (long_press),
        .double_click(double_click),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, k);
        end
    endtask

    task automatic model_clear();
        tp1 = -1;
        tr1 = -1;
        tp2 = -1;
        lng = 0;
    endtask

    task automatic model_edge(input bit lvl, input bit rst);
        bit rise, fall;
        k++;
        m_short = 0;
        m_long  = 0;
        m_dbl   = 0;
        if (rst) begin
            model_clear();
            mprev = 1;
        end else begin
            rise  = lvl && !mprev;
            fall  = !lvl && mprev;
            mprev = lvl;
            if (tp1 < 0) begin
                if (rise) tp1 = k;
            end else if (lng) begin
                if (fall) model_clear();
            end else if (tr1 < 0) begin
                if (fall) tr1 = k;
                else if (k - tp1 == LONG_T) begin
                    m_long = 1;
                    lng    = 1;
                end
            end else if (tp2 < 0) begin
                if (rise) tp2 = k;
                else if (k - tr1 == GAP_T) begin
                    m_short = 1;
                    model_clear();
                end
            end else if (fall) begin
                m_dbl = 1;
                model_clear();
            end
        end
        m_busy = (tp1 >= 0);
    endtask

    task automatic step(input logic lvl, input logic rst);
        db_level = lvl;
        reset    = rst;
        @(posedge clk);
        #1;
        model_edge(lvl, rst);
        check_eq("short_press", int'(short_press), int'(m_short));
        check_eq("long_press", int'(long_press), int'(m_long));
        check_eq("double_click", int'(double_click), int'(m_dbl));
        check_eq("busy", int'(busy), int'(m_busy));
        check_eq("one_pulse", int'($countones({short_press, long_press, double_click}) <= 1), 1);
        if (short_press) begin c_short++; k_short = k; end
        if (long_press)  begin c_long++;  k_long  = k; end
        if (double_click) begin c_dbl++;  k_dbl   = k; end
    endtask

    task automatic run(input logic lvl, input int n);
        for (int i = 0; i < n; i++) step(lvl, 1'b0);
    endtask

    task automatic new_scenario();
        c_short = 0; c_long = 0; c_dbl = 0;
        k_short = -1; k_long = -1; k_dbl = -1;
    endtask

    initial begin
        int k_ref;
        db_level = 1'b0;
        reset    = 1'b1;

        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        check_eq("reset_busy", int'(busy), 0);
        check_eq("reset_pulses", int'({short_press, long_press, double_click}), 0);
        run(1'b0, 3);

        // short click
        new_scenario();
        run(1'b1, 3);
        step(1'b0, 1'b0);
        k_ref = k;
        run(1'b0, 9);
        check_eq("A_short_count", c_short, 1);
        check_eq("A_short_latency", k_short - k_ref, 4);
        check_eq("A_other", c_long + c_dbl, 0);
        check_eq("A_busy", int'(busy), 0);

        // long press
        new_scenario();
        step(1'b1, 1'b0);
        k_ref = k;
        run(1'b1, 19);
        run(1'b0, 6);
        check_eq("B_long_count", c_long, 1);
        check_eq("B_long_latency", k_long - k_ref, 8);
        check_eq("B_other", c_short + c_dbl, 0);
        check_eq("B_busy", int'(busy), 0);

        // double click
        new_scenario();
        run(1'b1, 2);
        run(1'b0, 2);
        run(1'b1, 5);
        step(1'b0, 1'b0);
        k_ref = k;
        run(1'b0, 6);
        check_eq("C_dbl_count", c_dbl, 1);
        check_eq("C_dbl_edge", k_dbl, k_ref);
        check_eq("C_other", c_short + c_long, 0);

        // gap expires on the last low cycle, next press is a fresh gesture
        new_scenario();
        run(1'b1, 2);
        run(1'b0, 5);
        check_eq("D_first_short", c_short, 1);
        step(1'b1, 1'b0);
        check_eq("D_fresh_busy", int'(busy), 1);
        run(1'b1, 2);
        run(1'b0, 8);
        check_eq("D_short_count", c_short, 2);
        check_eq("D_other", c_long + c_dbl, 0);

        // reset while waiting in the release gap
        new_scenario();
        run(1'b1, 2);
        run(1'b0, 2);
        step(1'b0, 1'b1);
        check_eq("E_busy", int'(busy), 0);
        check_eq("E_pulses", int'({short_press, long_press, double_click}), 0);
        run(1'b0, 8);
        check_eq("E_count", c_short + c_long + c_dbl, 0);

        // button held across reset release
        new_scenario();
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        run(1'b1, 30);
        check_eq("F_count", c_short + c_long + c_dbl, 0);
        check_eq("F_busy", int'(busy), 0);
        run(1'b0, 3);

        // random level runs with occasional resets
        for (int r = 0; r < 400; r++) begin
            logic lvl;
            lvl = logic'($urandom_range(0, 1));
            if ($urandom_range(0, 40) == 0) step(lvl, 1'b1);
            run(lvl, int'($urandom_range(1, 12)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
